posit_decode_pipe: RTL and testbench
====================================

# posit_decode_pipe

Pipelined posit decoder for the posit datapath. It converts a packed WIDTH-bit posit encoding into unpacked fields: sign, zero/inf flags, biased unsigned exponent and left-aligned fraction. Those fields are the same ones the encode and round path consumes, so this block feeds the arithmetic units on the input side. It is two stages deep, has a valid/ready handshake on both sides, and sustains one posit per cycle.

## Interface
- WIDTH, 8: posit width in bits, ≥4.
- ES, 1: exponent-field bits, ≥0.
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- inValid  in  1  input word valid.
- inReady  out  1  block accepts the input word this cycle.
- inPosit  in  WIDTH  packed posit.
- outValid  out  1  decoded result valid.
- outReady  in  1  downstream accepts the result.
- outSign  out  1  sign of the value.
- outIsZero  out  1  input was all zeros.
- outIsInf  out  1  input was 1 followed by zeros (NaR/inf).
- outExponent  out  PositDef::getUnsignedExponentBits(WIDTH,ES)  equals {unsignedRegime, esBits}.
- outFraction  out  PositDef::getFractionBits(WIDTH,ES) = WIDTH-3  fraction without the hidden bit, MSB-aligned, zero-padded.

## Operation
- Sign: s = inPosit[WIDTH-1]. If s=1, decode the two's complement of inPosit.
- Regime: let r = bit WIDTH-2 of the (possibly negated) word. m is the run length of bits equal to r, counted from bit WIDTH-2 downward, with 1 ≤ m ≤ WIDTH-1.
  - k = m-1 when r=1; k = -m when r=0.
  - k lies in [-(WIDTH-2), WIDTH-2].
  - unsignedRegime = k + (WIDTH-2), in the range 0..2·WIDTH-4.
- Remaining bits: shift the word left by m+1 (regime run plus terminator) and fill with zeros.
  - The top ES bits are esBits. Any bits truncated off the bottom of the word read as 0.
  - The next WIDTH-3 bits are outFraction.
- Special cases:
  - 0 gives outIsZero=1 with sign, exponent and fraction all 0.
  - 1 followed by WIDTH-1 zeros gives outIsInf=1 with sign, exponent and fraction all 0.
  - outIsZero and outIsInf are never both 1.
- Pipeline stages:
  - S1 registers: sign, negated magnitude, m, r, and the special-case flags.
  - S2 performs the shift and exponent assembly and registers the outputs.
- Handshake:
  - A stage loads when it is empty or its contents are leaving.
  - inReady = !s1Valid || (!s2Valid || outReady).
  - Transfer happens on valid&&ready.
  - Output data holds stable while outValid && !outReady.

## Timing
- Latency is 2 cycles: a word accepted at edge n appears on outValid/data after edge n+2 when outReady stays high.
- Throughput is 1 word per cycle with no bubbles while outReady=1.
- With outReady low, the block holds at most 2 words, then deasserts inReady. When outReady returns, inReady rises combinationally in the same cycle.
- Simultaneous accept and emit on a full pipe is legal and loses no data.
- Reset:
  - resetn low immediately clears s1Valid, s2Valid and outValid to 0, and all output data registers to 0.
  - inReady is 1 during and after reset.
  - Words in flight at reset are discarded.
- No combinational path runs from inPosit to any output. inReady depends combinationally on outReady only.

## Structure
- Width functions come from the shared PositDef package: getFractionBits, getUnsignedRegimeBits, getUnsignedExponentBits.
- Add one function to PositDef: getRegimeCountBits(WIDTH) = clog2(WIDTH).
- Output field order matches the PositUnpacked interface so that a wrapper can bind the flat ports to it.
- One sub-module, posit_regime_count. It is combinational: from WIDTH-1 bits it produces r and m, implemented as a leading-run counter (a leading-zero count on the word XORed with replicated r).
- Elaboration assertions:
  - WIDTH ≥ 4.
  - ES ≤ WIDTH-3.
  - getUnsignedExponentBits - ES == getUnsignedRegimeBits.

## Test plan
All scenarios use WIDTH=8, ES=1, exponent width 5 and fraction width 5.
- 0x40 -> sign 0, exponent 12, fraction 00000. 0x5B -> exponent 13, fraction 10110.
- 0xC0 -> sign 1, exponent 12, fraction 0. 0x7F -> exponent 24, fraction 0. 0x01 -> exponent 0, fraction 0.
- 0x00 -> outIsZero=1. 0x80 -> outIsInf=1. In both cases the other fields are 0.
- Exhaustive 256-word stream with outReady=1 -> matches the reference model in order, each result exactly 2 cycles after input, no bubbles.
- Random outReady (50%) with continuous inValid -> no drops or duplicates, data stable while stalled, inReady=0 only when both stages are full.
- Assert resetn mid-stream with 2 words in flight -> outValid=0 immediately. After release, the next input emerges 2 cycles later and no stale data appears.

Source files
------------

// File: rtl/posit_decode_pipe_pkg.sv
// Shared posit width helpers used by the decode pipe, its interface and the regime counter.
package PositDef;

  // The fraction field width does not depend on es; es is kept for a uniform signature.
  function automatic int getFractionBits(input int width, input int es);
    return width - 3 + (es - es);
  endfunction

  function automatic int getUnsignedRegimeBits(input int width);
    return $clog2(2 * width - 3);
  endfunction

  function automatic int getUnsignedExponentBits(input int width, input int es);
    return getUnsignedRegimeBits(width) + es;
  endfunction

  function automatic int getRegimeCountBits(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Valid/ready input and output bundle of the posit decoder; the decoder takes the slave side.
interface posit_decode_pipe_if
  import PositDef::*;
#(
  parameter int WIDTH = 8,
  parameter int ES    = 1
);

  localparam int expWidth  = getUnsignedExponentBits(WIDTH, ES);
  localparam int fracWidth = getFractionBits(WIDTH, ES);

  logic                 inValid;
  logic                 inReady;
  logic [WIDTH-1:0]     inPosit;
  logic                 outValid;
  logic                 outReady;
  logic                 outSign;
  logic                 outIsZero;
  logic                 outIsInf;
  logic [expWidth-1:0]  outExponent;
  logic [fracWidth-1:0] outFraction;

  modport master (
    output inValid, inPosit, outReady,
    input  inReady, outValid, outSign, outIsZero, outIsInf, outExponent, outFraction
  );

  modport slave (
    input  inValid, inPosit, outReady,
    output inReady, outValid, outSign, outIsZero, outIsInf, outExponent, outFraction
  );

endinterface

// File: rtl/posit_regime_count.sv
// Finds the regime bit and the length of its leading run in the posit body (sign bit removed).
module posit_regime_count
  import PositDef::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-2:0]                       word,
  output logic                                   regimeBit,
  output logic [getRegimeCountBits(WIDTH)-1:0]   runLength
);

  localparam int cntWidth = getRegimeCountBits(WIDTH);

  logic [WIDTH-2:0] flipped;

  // Flipping by the regime bit turns the run into leading zeros; the top bit is
  // always zero after the flip, so the count is at least 1, and an all-zero word
  // means the run fills the whole body.
  always_comb begin
    regimeBit = word[WIDTH-2];
    flipped   = word ^ {(WIDTH-1){regimeBit}};
    runLength = cntWidth'(WIDTH - 1);
    for (int i = 0; i <= WIDTH - 2; i++) begin
      if (flipped[i]) begin
        runLength = cntWidth'(WIDTH - 2 - i);
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: S1 negates and counts the regime run, S2 shifts out es/fraction.
module posit_decode_pipe
  import PositDef::*;
#(
  parameter int WIDTH = 8,
  parameter int ES    = 1
) (
  input logic               clock,
  input logic               resetn,
  posit_decode_pipe_if.slave bus
);

  localparam int expWidth   = getUnsignedExponentBits(WIDTH, ES);
  localparam int fracWidth  = getFractionBits(WIDTH, ES);
  localparam int regWidth   = getUnsignedRegimeBits(WIDTH);
  localparam int cntWidth   = getRegimeCountBits(WIDTH);
  localparam int fieldWidth = ES + fracWidth;

  if (WIDTH < 4) begin : gWidthCheck
    $error("posit_decode_pipe: WIDTH must be at least 4");
  end
  if (ES > WIDTH - 3) begin : gEsCheck
    $error("posit_decode_pipe: ES must not exceed WIDTH-3");
  end
  if (expWidth - ES != regWidth) begin : gExpCheck
    $error("posit_decode_pipe: exponent width must equal regime width plus ES");
  end

  logic                 inSign;
  logic                 inZero;
  logic                 inInf;
  logic [WIDTH-2:0]     inBody;
  logic                 inRegimeBit;
  logic [cntWidth-1:0]  inRun;

  logic                 s1Valid;
  logic                 s1Sign;
  logic                 s1Zero;
  logic                 s1Inf;
  logic                 s1RegimeBit;
  logic [WIDTH-2:0]     s1Body;
  logic [cntWidth-1:0]  s1Run;

  logic [regWidth-1:0]   s1URegime;
  logic [fieldWidth-1:0] s1Fields;
  logic [expWidth-1:0]   s1Exponent;
  logic [fracWidth-1:0]  s1Fraction;

  logic s2Valid;
  logic s1Load;
  logic s2Load;

  // A stage loads when it is empty or its current word is leaving.
  assign s2Load       = !s2Valid || bus.outReady;
  assign s1Load       = !s1Valid || s2Load;
  assign bus.inReady  = s1Load;
  assign bus.outValid = s2Valid;

  // Only the bits below the sign matter after negation, so negate in that width.
  always_comb begin
    inSign = bus.inPosit[WIDTH-1];
    inBody = inSign ? -bus.inPosit[WIDTH-2:0] : bus.inPosit[WIDTH-2:0];
    inZero = (bus.inPosit == '0);
    inInf  = (bus.inPosit == {1'b1, {(WIDTH-1){1'b0}}});
  end

  posit_regime_count #(
    .WIDTH(WIDTH)
  ) uRegimeCount (
    .word     (inBody),
    .regimeBit(inRegimeBit),
    .runLength(inRun)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1Valid     <= 1'b0;
      s1Sign      <= 1'b0;
      s1Zero      <= 1'b0;
      s1Inf       <= 1'b0;
      s1RegimeBit <= 1'b0;
      s1Body      <= '0;
      s1Run       <= '0;
    end else if (s1Load) begin
      s1Valid <= bus.inValid;
      if (bus.inValid) begin
        s1Sign      <= inSign;
        s1Zero      <= inZero;
        s1Inf       <= inInf;
        s1RegimeBit <= inRegimeBit;
        s1Body      <= inBody;
        s1Run       <= inRun;
      end
    end
  end

  // Drop the regime run and its terminator by shifting left m+1; bits that fall
  // off the bottom of the body come in as zeros below the field window.
  always_comb begin
    s1URegime = s1RegimeBit ? regWidth'(s1Run) + regWidth'(WIDTH - 3)
                            : regWidth'(WIDTH - 2) - regWidth'(s1Run);
    s1Fields  = fieldWidth'(({s1Body, {fieldWidth{1'b0}}} << ({1'b0, s1Run} + 1'b1)) >> (WIDTH - 1));
    s1Exponent = (expWidth'(s1URegime) << ES) | expWidth'(s1Fields >> fracWidth);
    s1Fraction = s1Fields[fracWidth-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2Valid         <= 1'b0;
      bus.outSign     <= 1'b0;
      bus.outIsZero   <= 1'b0;
      bus.outIsInf    <= 1'b0;
      bus.outExponent <= '0;
      bus.outFraction <= '0;
    end else if (s2Load) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        bus.outIsZero <= s1Zero;
        bus.outIsInf  <= s1Inf;
        if (s1Zero || s1Inf) begin
          bus.outSign     <= 1'b0;
          bus.outExponent <= '0;
          bus.outFraction <= '0;
        end else begin
          bus.outSign     <= s1Sign;
          bus.outExponent <= s1Exponent;
          bus.outFraction <= s1Fraction;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Randomized and directed bench for posit_decode_pipe against an arithmetic posit reference model.
module tb_posit_decode_pipe;
  import PositDef::*;

  localparam int WIDTH     = 8;
  localparam int ES        = 1;
  localparam int expWidth  = getUnsignedExponentBits(WIDTH, ES);
  localparam int fracWidth = getFractionBits(WIDTH, ES);

  typedef struct packed {
    logic                 sign;
    logic                 isZero;
    logic                 isInf;
    logic [expWidth-1:0]  exponent;
    logic [fracWidth-1:0] fraction;
  } result_t;

  typedef struct {
    result_t res;
    int      cycle;
  } pending_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  posit_decode_pipe_if #(.WIDTH(WIDTH), .ES(ES)) bus ();

  posit_decode_pipe #(
    .WIDTH(WIDTH),
    .ES   (ES)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int       assertCount = 0;
  int       failCount   = 0;
  int       cycleNum    = 0;
  pending_t expQ[$];
  logic     freeFlow    = 1'b0;
  logic     stalledPrev = 1'b0;
  result_t  heldPrev    = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  // Decode by counting the regime run and reading the tail as plain integers.
  function automatic result_t refModel(input logic [WIDTH-1:0] p);
    result_t res;
    int v, r, m, k, n, rest, tail;
    res = '0;
    if (p == 0) begin
      res.isZero = 1'b1;
      return res;
    end
    if (int'(p) == (1 << (WIDTH - 1))) begin
      res.isInf = 1'b1;
      return res;
    end
    res.sign = p[WIDTH-1];
    v = res.sign ? ((1 << WIDTH) - int'(p)) : int'(p);
    r = (v >> (WIDTH - 2)) & 1;
    m = 0;
    for (int b = WIDTH - 2; b >= 0; b--) begin
      if (((v >> b) & 1) != r) break;
      m++;
    end
    k = (r == 1) ? m - 1 : -m;
    n = WIDTH - 2 - m;
    if (n < 0) n = 0;
    rest = v & ((1 << n) - 1);
    tail = rest << (ES + fracWidth - n);
    res.exponent = expWidth'((k + WIDTH - 2) * (1 << ES) + (tail >> fracWidth));
    res.fraction = fracWidth'(tail & ((1 << fracWidth) - 1));
    return res;
  endfunction

  // One cycle: drive inputs after the edge, then check outputs and track handshakes.
  task automatic applyStimulus(input logic vIn, input logic [WIDTH-1:0] pIn, input logic rdy,
                               input logic useTable, input result_t tableRes);
    result_t  obs;
    pending_t ent;
    @(posedge clock);
    #1;
    cycleNum++;
    bus.inValid  = vIn;
    bus.inPosit  = pIn;
    bus.outReady = rdy;
    #1;
    obs = {bus.outSign, bus.outIsZero, bus.outIsInf, bus.outExponent, bus.outFraction};
    if (stalledPrev) begin
      checkOutput("holdValid", 32'(bus.outValid), 32'd1);
      checkOutput("holdStable", 32'(obs), 32'(heldPrev));
    end
    checkOutput("inReady", 32'(bus.inReady), 32'(!(expQ.size() == 2 && !rdy)));
    if (bus.outValid && rdy) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOut", 32'(bus.outValid), 32'd0);
      end else begin
        ent = expQ.pop_front();
        checkOutput("data", 32'(obs), 32'(ent.res));
        if (freeFlow) checkOutput("latency", 32'(cycleNum - ent.cycle), 32'd2);
      end
    end
    stalledPrev = bus.outValid && !rdy;
    heldPrev    = obs;
    if (vIn && bus.inReady) begin
      ent.res   = useTable ? tableRes : refModel(pIn);
      ent.cycle = cycleNum;
      expQ.push_back(ent);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    end
    checkOutput("drained", 32'(expQ.size()), 32'd0);
  endtask

  logic [WIDTH-1:0] tblPosit[8] = '{8'h40, 8'h5B, 8'hC0, 8'h7F, 8'h01, 8'h00, 8'h80, 8'hFF};
  result_t          tblRes[8]   = '{
    '{1'b0, 1'b0, 1'b0, 5'd12, 5'b00000},
    '{1'b0, 1'b0, 1'b0, 5'd13, 5'b10110},
    '{1'b1, 1'b0, 1'b0, 5'd12, 5'b00000},
    '{1'b0, 1'b0, 1'b0, 5'd24, 5'b00000},
    '{1'b0, 1'b0, 1'b0, 5'd0,  5'b00000},
    '{1'b0, 1'b1, 1'b0, 5'd0,  5'b00000},
    '{1'b0, 1'b0, 1'b1, 5'd0,  5'b00000},
    '{1'b1, 1'b0, 1'b0, 5'd0,  5'b00000}
  };

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.inValid  = 1'b0;
    bus.inPosit  = '0;
    bus.outReady = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetOutValid", 32'(bus.outValid), 32'd0);
    checkOutput("resetInReady", 32'(bus.inReady), 32'd1);
    checkOutput("resetData", 32'({bus.outSign, bus.outIsZero, bus.outIsInf, bus.outExponent, bus.outFraction}), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed words with hand-derived expected fields, streamed back to back.
    freeFlow = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, tblPosit[i], 1'b1, 1'b1, tblRes[i]);
    drain();

    for (int i = 0; i < 256; i++) applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0, '0);
    drain();

    freeFlow = 1'b0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    drain();

    // Two words in flight when reset hits; none of them may come out afterwards.
    freeFlow = 1'b1;
    applyStimulus(1'b1, 8'h5B, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 8'hC0, 1'b1, 1'b0, '0);
    @(posedge clock);
    #1;
    bus.inValid = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("midResetOutValid", 32'(bus.outValid), 32'd0);
    checkOutput("midResetInReady", 32'(bus.inReady), 32'd1);
    checkOutput("midResetData", 32'({bus.outSign, bus.outIsZero, bus.outIsInf, bus.outExponent, bus.outFraction}), 32'd0);
    expQ.delete();
    stalledPrev = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(1'b1, 8'h7F, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("postResetDrained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
